// File: rtl/fpu_reservation_station_pkg.sv
// Shared FPU issue types: operand sources, dispatched instructions and writeback results.
package fpu_reservation_station_pkg;

    localparam int unsigned DataW     = 32;
    localparam int unsigned PhysRegW  = 6;
    localparam int unsigned CommitIdW = 6;
    localparam int unsigned LogicRegW = 5;
    localparam int unsigned Funct5W   = 5;

    typedef struct packed {
        logic [DataW-PhysRegW-1:0] rsvd;
        logic [PhysRegW-1:0]       phys;
    } src_tag_t;

    typedef union packed {
        logic [DataW-1:0] data;
        src_tag_t         tag;
    } src_content_t;

    typedef struct packed {
        logic         valid;
        src_content_t content;
    } source_t;

    typedef struct packed {
        logic [CommitIdW-1:0] commit_id;
        logic [PhysRegW-1:0]  dest_phys;
        logic [LogicRegW-1:0] dest_logic;
        logic [Funct5W-1:0]   funct5;
        source_t              src1;
        source_t              src2;
    } fpu_instr_t;

    typedef enum logic [1:0] {
        KindWb   = 2'd0,
        KindExc  = 2'd1,
        KindCsr  = 2'd2,
        KindNone = 2'd3
    } result_kind_e;

    typedef struct packed {
        logic [PhysRegW-1:0] dest_phys;
        logic [DataW-1:0]    data;
    } wb_result_t;

    typedef union packed {
        wb_result_t                  wb;
        logic [PhysRegW+DataW-1:0]   raw;
    } result_content_t;

    typedef struct packed {
        result_kind_e    kind;
        result_content_t content;
    } result_t;

    function automatic logic wb_hit(input logic en, input result_t msg, input source_t src);
        return en && (msg.kind == KindWb) && !src.valid &&
               (msg.content.wb.dest_phys == src.content.tag.phys);
    endfunction

endpackage

// File: rtl/fpu_rs_wakeup_match.sv
// Captures a missing operand from either writeback bus; bus 0 wins when both hit.
module fpu_rs_wakeup_match
    import fpu_reservation_station_pkg::*;
(
    input  source_t src_i,
    input  logic    wakeup0_en_i,
    input  result_t wakeup0_msg_i,
    input  logic    wakeup1_en_i,
    input  result_t wakeup1_msg_i,
    output source_t src_o,
    output logic    match_o
);
    logic hit0;
    logic hit1;

    always_comb begin
        hit0    = wb_hit(wakeup0_en_i, wakeup0_msg_i, src_i);
        hit1    = wb_hit(wakeup1_en_i, wakeup1_msg_i, src_i);
        src_o   = src_i;
        match_o = hit0 | hit1;
        if (hit0) begin
            src_o.valid        = 1'b1;
            src_o.content.data = wakeup0_msg_i.content.wb.data;
        end else if (hit1) begin
            src_o.valid        = 1'b1;
            src_o.content.data = wakeup1_msg_i.content.wb.data;
        end
    end

endmodule

// File: rtl/fpu_reservation_station.sv
// FPU issue queue: age-ordered compacting station with writeback operand capture.
// Optional FPU_RS_WAKEUP_BYPASS_EN: a same-cycle wakeup makes a stored entry ready at once.
module fpu_reservation_station
    import fpu_reservation_station_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       flash,
    input  logic       dispatch_en_i,
    input  fpu_instr_t dispatch_msg_i,
    output logic       dispatch_reject_o,
    output logic       issue_en_o,
    output fpu_instr_t issue_msg_o,
    input  logic       issue_reject_i,
    input  logic       wakeup0_en_i,
    input  result_t    wakeup0_msg_i,
    output logic       wakeup0_reject_o,
    input  logic       wakeup1_en_i,
    input  result_t    wakeup1_msg_i,
    output logic       wakeup1_reject_o
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = $clog2(DEPTH);

    typedef struct packed {
        logic       occupied;
        fpu_instr_t instr;
    } rs_entry_t;

    rs_entry_t        entries_q [DEPTH];
    rs_entry_t        entries_d [DEPTH];
    rs_entry_t        woken     [DEPTH];
    rs_entry_t        shifted   [DEPTH];
    source_t          src1_w    [DEPTH];
    source_t          src2_w    [DEPTH];
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;
    logic [DEPTH-1:0] ready;
    logic [CntW-1:0]  count_q, count_d;
    logic [CntW-1:0]  widx;
    logic [IdxW-1:0]  sel;
    logic             any_ready, issue_fire, accept;
    source_t          dsrc1_w, dsrc2_w;
    logic             dmatch1, dmatch2;
    fpu_instr_t       dispatch_w;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        fpu_rs_wakeup_match u_src1 (
            .src_i        (entries_q[g].instr.src1),
            .wakeup0_en_i (wakeup0_en_i),
            .wakeup0_msg_i(wakeup0_msg_i),
            .wakeup1_en_i (wakeup1_en_i),
            .wakeup1_msg_i(wakeup1_msg_i),
            .src_o        (src1_w[g]),
            .match_o      (match1[g])
        );
        fpu_rs_wakeup_match u_src2 (
            .src_i        (entries_q[g].instr.src2),
            .wakeup0_en_i (wakeup0_en_i),
            .wakeup0_msg_i(wakeup0_msg_i),
            .wakeup1_en_i (wakeup1_en_i),
            .wakeup1_msg_i(wakeup1_msg_i),
            .src_o        (src2_w[g]),
            .match_o      (match2[g])
        );
    end

    fpu_rs_wakeup_match u_dsrc1 (
        .src_i        (dispatch_msg_i.src1),
        .wakeup0_en_i (wakeup0_en_i),
        .wakeup0_msg_i(wakeup0_msg_i),
        .wakeup1_en_i (wakeup1_en_i),
        .wakeup1_msg_i(wakeup1_msg_i),
        .src_o        (dsrc1_w),
        .match_o      (dmatch1)
    );
    fpu_rs_wakeup_match u_dsrc2 (
        .src_i        (dispatch_msg_i.src2),
        .wakeup0_en_i (wakeup0_en_i),
        .wakeup0_msg_i(wakeup0_msg_i),
        .wakeup1_en_i (wakeup1_en_i),
        .wakeup1_msg_i(wakeup1_msg_i),
        .src_o        (dsrc2_w),
        .match_o      (dmatch2)
    );

    always_comb begin
        dispatch_w = dispatch_msg_i;
        if (dmatch1) dispatch_w.src1 = dsrc1_w;
        if (dmatch2) dispatch_w.src2 = dsrc2_w;
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            woken[i] = entries_q[i];
            if (match1[i]) woken[i].instr.src1 = src1_w[i];
            if (match2[i]) woken[i].instr.src2 = src2_w[i];
`ifdef FPU_RS_WAKEUP_BYPASS_EN
            ready[i] = woken[i].occupied & woken[i].instr.src1.valid &
                       woken[i].instr.src2.valid;
`else
            ready[i] = entries_q[i].occupied & entries_q[i].instr.src1.valid &
                       entries_q[i].instr.src2.valid;
`endif
        end
    end

    // Oldest-first pick; independent of issue_reject_i so no loop through the handshake.
    always_comb begin
        sel       = '0;
        any_ready = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ready[i] && !any_ready) begin
                sel       = IdxW'(i);
                any_ready = 1'b1;
            end
        end
    end

    assign issue_en_o        = any_ready;
`ifdef FPU_RS_WAKEUP_BYPASS_EN
    assign issue_msg_o       = woken[sel].instr;
`else
    assign issue_msg_o       = entries_q[sel].instr;
`endif
    assign dispatch_reject_o = (count_q == CntW'(DEPTH));
    assign wakeup0_reject_o  = 1'b0;
    assign wakeup1_reject_o  = 1'b0;
    assign issue_fire        = any_ready & ~issue_reject_i;
    assign accept            = dispatch_en_i & ~dispatch_reject_o;
    assign widx              = count_q - CntW'(issue_fire);

    always_comb begin
        shifted[DEPTH-1] = '0;
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            shifted[i] = woken[i+1];
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entries_d[i] = woken[i];
            if (issue_fire && (IdxW'(i) >= sel)) entries_d[i] = shifted[i];
            if (accept && (CntW'(i) == widx)) begin
                entries_d[i].occupied = 1'b1;
                entries_d[i].instr    = dispatch_w;
            end
        end
        count_d = count_q + CntW'(accept) - CntW'(issue_fire);
        if (flash) begin
            count_d = '0;
            for (int unsigned i = 0; i < DEPTH; i++) entries_d[i] = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
        end else begin
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: tb/tb_fpu_reservation_station.sv
// Self-checking bench for fpu_reservation_station against an age-ordered queue model.
module tb_fpu_reservation_station;
    import fpu_reservation_station_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset, flash;
    logic       dispatch_en, dispatch_reject;
    fpu_instr_t dispatch_msg;
    logic       issue_en, issue_reject;
    fpu_instr_t issue_msg;
    logic       w0_en, w0_reject, w1_en, w1_reject;
    result_t    w0_msg, w1_msg;

    int checks = 0;
    int errors = 0;
    fpu_instr_t mq[$];

    always #5 clock = ~clock;

    fpu_reservation_station #(.DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .flash            (flash),
        .dispatch_en_i    (dispatch_en),
        .dispatch_msg_i   (dispatch_msg),
        .dispatch_reject_o(dispatch_reject),
        .issue_en_o       (issue_en),
        .issue_msg_o      (issue_msg),
        .issue_reject_i   (issue_reject),
        .wakeup0_en_i     (w0_en),
        .wakeup0_msg_i    (w0_msg),
        .wakeup0_reject_o (w0_reject),
        .wakeup1_en_i     (w1_en),
        .wakeup1_msg_i    (w1_msg),
        .wakeup1_reject_o (w1_reject)
    );

    function automatic source_t mk_src(input bit v, input logic [31:0] val);
        source_t s;
        s.valid        = v;
        s.content.data = v ? val : {{(DataW-PhysRegW){1'b0}}, val[PhysRegW-1:0]};
        return s;
    endfunction

    function automatic fpu_instr_t mk_instr(input int cid, input source_t a, input source_t b);
        fpu_instr_t x;
        x.commit_id  = CommitIdW'(cid);
        x.dest_phys  = PhysRegW'($urandom());
        x.dest_logic = LogicRegW'($urandom());
        x.funct5     = Funct5W'($urandom());
        x.src1       = a;
        x.src2       = b;
        return x;
    endfunction

    function automatic source_t rand_src();
        bit v = bit'($urandom_range(0, 1));
        return mk_src(v, v ? 32'($urandom()) : 32'($urandom_range(0, 7)));
    endfunction

    function automatic result_t mk_wb(input int phys, input logic [31:0] data);
        result_t r;
        r.kind                 = KindWb;
        r.content.wb.dest_phys = PhysRegW'(phys);
        r.content.wb.data      = data;
        return r;
    endfunction

    // Reference model: a source waiting on tag T takes the data of the first bus broadcasting T.
    function automatic source_t m_wake(input source_t s);
        if (!s.valid) begin
            if (w0_en && w0_msg.kind == KindWb &&
                w0_msg.content.wb.dest_phys == s.content.tag.phys) begin
                s.valid        = 1'b1;
                s.content.data = w0_msg.content.wb.data;
            end else if (w1_en && w1_msg.kind == KindWb &&
                         w1_msg.content.wb.dest_phys == s.content.tag.phys) begin
                s.valid        = 1'b1;
                s.content.data = w1_msg.content.wb.data;
            end
        end
        return s;
    endfunction

    function automatic fpu_instr_t m_view(input int i);
        fpu_instr_t e = mq[i];
`ifdef FPU_RS_WAKEUP_BYPASS_EN
        e.src1 = m_wake(e.src1);
        e.src2 = m_wake(e.src2);
`endif
        return e;
    endfunction

    function automatic int m_sel();
        fpu_instr_t e;
        for (int i = 0; i < mq.size(); i++) begin
            e = m_view(i);
            if (e.src1.valid && e.src2.valid) return i;
        end
        return -1;
    endfunction

    task automatic idle();
        reset        = 1'b0;
        flash        = 1'b0;
        dispatch_en  = 1'b0;
        issue_reject = 1'b0;
        w0_en        = 1'b0;
        w1_en        = 1'b0;
    endtask

    // Apply the current inputs to the model, then move to just after the next edge.
    task automatic advance();
        int         s;
        bit         fire, acc;
        fpu_instr_t d;
        if (reset || flash) begin
            mq.delete();
        end else begin
            s    = m_sel();
            fire = (s >= 0) && !issue_reject;
            acc  = dispatch_en && (mq.size() < DEPTH);
            foreach (mq[i]) begin
                mq[i].src1 = m_wake(mq[i].src1);
                mq[i].src2 = m_wake(mq[i].src2);
            end
            if (fire) mq.delete(s);
            if (acc) begin
                d      = dispatch_msg;
                d.src1 = m_wake(d.src1);
                d.src2 = m_wake(d.src2);
                mq.push_back(d);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset        = 1'b1;
        dispatch_en  = 1'b1;
        dispatch_msg = mk_instr(63, mk_src(1, 32'h1), mk_src(1, 32'h2));
        advance();
        advance();
        idle();
        #1;
        checks++;
        if (issue_en !== 1'b0) begin
            errors++; $display("FAIL reset_issue_en: got %b want 0", issue_en);
        end
        checks++;
        if (dispatch_reject !== 1'b0) begin
            errors++; $display("FAIL reset_dispatch_reject: got %b want 0", dispatch_reject);
        end
        checks++;
        if (dut.count_q !== 3'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", dut.count_q);
        end
        advance();
    endtask

    task automatic test_basic();
        fpu_instr_t x;
        idle();
        x        = mk_instr(1, mk_src(1, 32'h3f800000), mk_src(1, 32'h40000000));
        x.funct5 = '0;
        dispatch_en  = 1'b1;
        dispatch_msg = x;
        #1;
        advance();
        idle();
        #1;
        checks++;
        if (issue_en !== 1'b1) begin
            errors++; $display("FAIL basic_issue_en: got %b want 1", issue_en);
        end
        checks++;
        if (issue_msg !== x) begin
            errors++; $display("FAIL basic_issue_msg: got %h want %h", issue_msg, x);
        end
        advance();
        #1;
        checks++;
        if (dut.count_q !== 3'd0 || issue_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: got count %0d en %b want 0 0", dut.count_q, issue_en);
        end
    endtask

    task automatic test_wakeup();
        idle();
        dispatch_en  = 1'b1;
        dispatch_msg = mk_instr(2, mk_src(0, 32'd5), mk_src(1, 32'h12345678));
        advance();
        idle();
        #1;
        checks++;
        if (issue_en !== 1'b0) begin
            errors++; $display("FAIL wakeup_wait: got %b want 0", issue_en);
        end
        advance();
        w1_en  = 1'b1;
        w1_msg = mk_wb(5, 32'h41200000);
        #1;
`ifdef FPU_RS_WAKEUP_BYPASS_EN
        checks++;
        if (issue_en !== 1'b1 || issue_msg.src1 !== mk_src(1, 32'h41200000)) begin
            errors++; $display("FAIL wakeup_bypass: got en %b src1 %h want 1 %h",
                               issue_en, issue_msg.src1, mk_src(1, 32'h41200000));
        end
        advance();
        idle();
        #1;
        checks++;
        if (issue_en !== 1'b0) begin
            errors++; $display("FAIL wakeup_after: got %b want 0", issue_en);
        end
`else
        checks++;
        if (issue_en !== 1'b0) begin
            errors++; $display("FAIL wakeup_same_cycle: got %b want 0", issue_en);
        end
        advance();
        idle();
        #1;
        checks++;
        if (issue_en !== 1'b1 || issue_msg.src1 !== mk_src(1, 32'h41200000)) begin
            errors++; $display("FAIL wakeup_next_cycle: got en %b src1 %h want 1 %h",
                               issue_en, issue_msg.src1, mk_src(1, 32'h41200000));
        end
`endif
        advance();
    endtask

    task automatic test_same_cycle();
        idle();
        dispatch_en  = 1'b1;
        dispatch_msg = mk_instr(3, mk_src(0, 32'd7), mk_src(1, 32'h0));
        w0_en        = 1'b1;
        w0_msg       = mk_wb(7, 32'hC0000000);
        #1;
        checks++;
        if (issue_en !== 1'b0) begin
            errors++; $display("FAIL capture_no_bypass: got %b want 0", issue_en);
        end
        advance();
        idle();
        #1;
        checks++;
        if (issue_en !== 1'b1 || issue_msg.src1 !== mk_src(1, 32'hC0000000)) begin
            errors++; $display("FAIL capture_issue: got en %b src1 %h want 1 %h",
                               issue_en, issue_msg.src1, mk_src(1, 32'hC0000000));
        end
        advance();
    endtask

    task automatic test_full_reject();
        idle();
        issue_reject = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dispatch_en  = 1'b1;
            dispatch_msg = mk_instr(10 + k, rand_src(), rand_src());
            dispatch_msg.src1 = mk_src(1, 32'($urandom()));
            dispatch_msg.src2 = mk_src(1, 32'($urandom()));
            #1;
            checks++;
            if (dispatch_reject !== 1'b0) begin
                errors++; $display("FAIL fill_reject[%0d]: got %b want 0", k, dispatch_reject);
            end
            advance();
        end
        for (int k = 0; k < 3; k++) begin
            dispatch_en  = 1'b1;
            dispatch_msg = mk_instr(14, mk_src(1, 32'h1), mk_src(1, 32'h2));
            #1;
            checks++;
            if (dispatch_reject !== 1'b1 || issue_en !== 1'b1 ||
                issue_msg.commit_id !== CommitIdW'(10)) begin
                errors++; $display("FAIL hold[%0d]: got rej %b en %b cid %0d want 1 1 10",
                                   k, dispatch_reject, issue_en, issue_msg.commit_id);
            end
            advance();
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (issue_en !== 1'b1 || issue_msg.commit_id !== CommitIdW'(10 + k)) begin
                errors++; $display("FAIL drain[%0d]: got en %b cid %0d want 1 %0d",
                                   k, issue_en, issue_msg.commit_id, 10 + k);
            end
            checks++;
            if (dispatch_reject !== (k == 0)) begin
                errors++; $display("FAIL drain_reject[%0d]: got %b want %b",
                                   k, dispatch_reject, (k == 0));
            end
            advance();
        end
    endtask

    task automatic test_ooo();
        logic [31:0] d9;
        d9 = $urandom();
        idle();
        dispatch_en  = 1'b1;
        dispatch_msg = mk_instr(20, mk_src(0, 32'd9), mk_src(1, 32'h5));
        advance();
        dispatch_msg = mk_instr(21, mk_src(1, 32'h6), mk_src(1, 32'h7));
        advance();
        dispatch_msg = mk_instr(22, mk_src(1, 32'h8), mk_src(0, 32'd9));
        #1;
        checks++;
        if (issue_en !== 1'b1 || issue_msg.commit_id !== CommitIdW'(21)) begin
            errors++; $display("FAIL ooo_first: got en %b cid %0d want 1 21",
                               issue_en, issue_msg.commit_id);
        end
        advance();
        idle();
        #1;
        checks++;
        if (issue_en !== 1'b0 || dut.count_q !== 3'd2) begin
            errors++; $display("FAIL ooo_wait: got en %b count %0d want 0 2",
                               issue_en, dut.count_q);
        end
        advance();
        w0_en  = 1'b1;
        w0_msg = mk_wb(9, d9);
        #1;
`ifdef FPU_RS_WAKEUP_BYPASS_EN
        checks++;
        if (issue_en !== 1'b1 || issue_msg.commit_id !== CommitIdW'(20)) begin
            errors++; $display("FAIL ooo_bypass: got en %b cid %0d want 1 20",
                               issue_en, issue_msg.commit_id);
        end
        advance();
        idle();
`else
        advance();
        idle();
        #1;
        checks++;
        if (issue_en !== 1'b1 || issue_msg.commit_id !== CommitIdW'(20) ||
            issue_msg.src1 !== mk_src(1, d9)) begin
            errors++; $display("FAIL ooo_second: got en %b cid %0d want 1 20",
                               issue_en, issue_msg.commit_id);
        end
        advance();
`endif
        #1;
        checks++;
        if (issue_en !== 1'b1 || issue_msg.commit_id !== CommitIdW'(22) ||
            issue_msg.src2 !== mk_src(1, d9)) begin
            errors++; $display("FAIL ooo_third: got en %b cid %0d want 1 22",
                               issue_en, issue_msg.commit_id);
        end
        advance();
    endtask

    task automatic test_flash();
        for (int pass = 0; pass < 2; pass++) begin
            idle();
            for (int k = 0; k < 3; k++) begin
                dispatch_en  = 1'b1;
                dispatch_msg = mk_instr(30 + k, mk_src(0, 32'd31), mk_src(1, 32'h9));
                advance();
            end
            dispatch_msg = mk_instr(33, mk_src(1, 32'h1), mk_src(1, 32'h2));
            if (pass == 0) flash = 1'b1;
            else reset = 1'b1;
            advance();
            idle();
            w0_en  = 1'b1;
            w0_msg = mk_wb(31, 32'hdeadbeef);
            #1;
            checks++;
            if (dut.count_q !== 3'd0 || issue_en !== 1'b0 || dispatch_reject !== 1'b0) begin
                errors++; $display("FAIL flush[%0d]: got count %0d en %b rej %b want 0 0 0",
                                   pass, dut.count_q, issue_en, dispatch_reject);
            end
            advance();
            idle();
            #1;
            checks++;
            if (issue_en !== 1'b0) begin
                errors++; $display("FAIL flush_empty[%0d]: got %b want 0", pass, issue_en);
            end
        end
    endtask

    task automatic test_random();
        int s;
        for (int n = 0; n < 800; n++) begin
            reset        = 1'b0;
            flash        = ($urandom_range(0, 59) == 0);
            dispatch_en  = bit'($urandom_range(0, 1));
            dispatch_msg = mk_instr(int'($urandom_range(0, 63)), rand_src(), rand_src());
            issue_reject = ($urandom_range(0, 3) == 0);
            w0_en        = bit'($urandom_range(0, 1));
            w0_msg       = mk_wb(int'($urandom_range(0, 7)), $urandom());
            if ($urandom_range(0, 7) == 0) w0_msg.kind = KindExc;
            w1_en        = bit'($urandom_range(0, 1));
            w1_msg       = mk_wb(int'($urandom_range(0, 7)), $urandom());
            if ($urandom_range(0, 7) == 0) w1_msg.kind = KindCsr;
            #1;
            s = m_sel();
            checks++;
            if (issue_en !== (s >= 0)) begin
                errors++; $display("FAIL rnd_issue_en[%0d]: got %b want %b", n, issue_en, s >= 0);
            end
            if (s >= 0) begin
                checks++;
                if (issue_msg !== m_view(s)) begin
                    errors++; $display("FAIL rnd_issue_msg[%0d]: got %h want %h",
                                       n, issue_msg, m_view(s));
                end
            end
            checks++;
            if (dispatch_reject !== (mq.size() == DEPTH)) begin
                errors++; $display("FAIL rnd_reject[%0d]: got %b want %b",
                                   n, dispatch_reject, mq.size() == DEPTH);
            end
            checks++;
            if (int'(dut.count_q) != mq.size()) begin
                errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d",
                                   n, dut.count_q, mq.size());
            end
            advance();
        end
    endtask

    initial begin
        idle();
        dispatch_msg = '0;
        w0_msg       = '0;
        w1_msg       = '0;
        test_reset();
        test_basic();
        test_wakeup();
        test_same_cycle();
        test_full_reject();
        test_ooo();
        test_flash();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
